rr_arb8_ctrl: RTL

Round-robin arbiter and select generator for the 8:1 single-bit mux. Eight requesters compete for the shared mux output. The block grants one requester at a time and drives the mux `sel` with the granted index. It holds the grant until the requester releases it, or until a hold limit expires when that feature is compiled in.

---
 rtl/rr_arb8_pkg.sv | 22 ++
 rtl/rr_pick8.sv | 25 ++
 rtl/rr_arb8_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
// Provides the arbiter state enum and a one-hot to index helper.
package rr_arb8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set bit of cand at or
// after index start, scanning upward with wrap from 7 to 0.
module rr_pick8
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   low;

    always_comb begin
        // Rotate so that bit 0 of rot is cand[start], then isolate the lowest set bit.
        dbl   = {cand, cand} >> start;
        rot   = dbl[N_REQ-1:0];
        low   = rot & (~rot + {{(N_REQ-1){1'b0}}, 1'b1});
        found = |cand;
        idx   = onehot_to_idx(low) + start;
    end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter and select generator for an 8:1 single-bit mux.
// Optional hold-limit preemption is built when RR_ARB8_HOLD_LIMIT_EN is defined.
module rr_arb8_ctrl
    import rr_arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 2..256");
    end

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] last_r, last_nxt;
    logic [SEL_W-1:0] sel_r, sel_nxt;
    logic [N_REQ-1:0] gnt_r, gnt_nxt;
    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             req_held;
    logic             hold_expire;
    logic             load;

    assign req_held = |(req & gnt_r);
    // While granted, the current owner is excluded so a handoff never re-picks it.
    assign cand     = (state == ARB_GRANT) ? (req & ~gnt_r) : req;

    rr_pick8 u_pick (
        .cand  (cand),
        .start (last_r + SEL_W'(1)),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    load      = 1'b1;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (req_held) begin
                    if (hold_expire && pick_found) load = 1'b1;
                end else if (pick_found) begin
                    load = 1'b1;
                end else begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt  = gnt_r;
        sel_nxt  = sel_r;
        last_nxt = last_r;
        if (load) begin
            gnt_nxt           = '0;
            gnt_nxt[pick_idx] = 1'b1;
            sel_nxt           = pick_idx;
            last_nxt          = pick_idx;
        end else if (state_nxt == ARB_IDLE) begin
            gnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r  <= '0;
            sel_r  <= '0;
            last_r <= SEL_W'(N_REQ - 1);
        end else begin
            gnt_r  <= gnt_nxt;
            sel_r  <= sel_nxt;
            last_r <= last_nxt;
        end
    end

`ifdef RR_ARB8_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       timeout_r;

    assign hold_expire = (hold_cnt == HOLD_LAST);

    // Counter saturates so a lone requester keeps its grant without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= load && (state == ARB_GRANT) && req_held;
            if (load)
                hold_cnt <= '0;
            else if (state == ARB_GRANT && !hold_expire)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign timeout = timeout_r;
`else
    assign hold_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign gnt   = gnt_r;
    assign sel   = sel_r;
    assign valid = |gnt_r;

endmodule
